// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared constants and types for the FIFO write-port arbiter.
//   N_REQ_DEF / DW_DEF / DEPTH_DEF : default producer count, data width, and
//                                   usable FIFO depth (credit ceiling)
//   arb_state_t                    : IDLE (no write this cycle) / ISSUE (write)
//   byte_t                         : one byte of producer data
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search starts at last_i+1 and wraps
// modulo N; the first eligible producer found wins.
// Ports:
//   eligible_i [N-1:0]  : producers that may be granted this cycle
//   last_i     [IW-1:0] : index of the most recent grant
//   grant_o    [N-1:0]  : one-hot grant (all zero when nothing is eligible)
//   idx_o      [IW-1:0] : index of the granted producer
//   valid_o             : a grant was found
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    logic [IW-1:0] cand_idx;
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_idx = '0;
    // Offsets 1..N visit every producer once, ending on last_i itself, so the
    // previous winner has the lowest priority.
    for (int off = 1; off <= N; off++) begin
      cand_idx = IW'((int'(last_i) + off) % N);
      if (!valid_o && eligible_i[cand_idx]) begin
        valid_o           = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin write-port scheduler letting N_REQ byte producers share one
// synchronous FIFO. A private credit counter tracks FIFO occupancy so no write
// is issued that could overflow, even though the FIFO Full flag lags a cycle.
// Optional feature macro: FIFO_ARB_PRIO0_EN -- producer 0 gets strict priority,
// the others round-robin among themselves.
// Ports:
//   clk, rst (async, active-low)
//   req[N_REQ], req_data[N_REQ*DW] : producer requests and flattened data
//   fifo_full, fifo_rd, fifo_empty : FIFO status / consumer read strobe
//   fifo_wd, fifo_data             : registered FIFO write enable and data
//   ack[N_REQ]                     : registered one-hot acceptance pulse
//   grant_id                       : registered index of last granted producer
//   credits_used                   : arbiter's view of FIFO occupancy
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*DW-1:0]          req_data,
  input  logic                         fifo_full,
  input  logic                         fifo_rd,
  input  logic                         fifo_empty,
  output logic                         fifo_wd,
  output logic [DW-1:0]                fifo_data,
  output logic [N_REQ-1:0]             ack,
  output logic [$clog2(N_REQ)-1:0]     grant_id,
  output logic [$clog2(DEPTH+1)-1:0]   credits_used
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  arb_state_t       state_q;
  logic [DW-1:0]    fifo_data_q;
  logic [N_REQ-1:0] ack_q;
  logic [IW-1:0]    grant_id_q;
  logic [IW-1:0]    last_grant_q;
  logic [CW-1:0]    credits_q;

  logic             wr_active;
  logic             issue_ok;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] rr_elig;
  logic [N_REQ-1:0] rr_grant;
  logic [IW-1:0]    rr_idx;
  logic             rr_valid;
  logic [N_REQ-1:0] grant_d;
  logic [IW-1:0]    grant_idx_d;
  logic             grant_vld_d;
  logic [IW-1:0]    last_grant_d;
  logic [DW-1:0]    data_d;
  logic [CW-1:0]    credits_d;
  logic             cred_inc;
  logic             cred_dec;
  logic [DW-1:0]    slice [N_REQ];

  // The write enable is the ISSUE state itself, so it is a registered output.
  assign wr_active = (state_q == ISSUE);

  // The write currently on the bus is not yet in credits_q, so it is added in
  // here. Reads are deliberately not credited until the next cycle.
  assign issue_ok = (({1'b0, credits_q} + (CW + 1)'(wr_active)) < DEPTH_W) && !fifo_full;

  // A producer whose ack is high this cycle still shows its old word, so it
  // must sit out one cycle to avoid writing that word twice.
  assign eligible = req & ~ack_q & {N_REQ{issue_ok}};

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

`ifdef FIFO_ARB_PRIO0_EN
  // Producer 0 is removed from the rotation and overrides it when eligible.
  assign rr_elig = eligible & {{(N_REQ-1){1'b1}}, 1'b0};

  always_comb begin
    if (eligible[0]) begin
      grant_d     = {{(N_REQ-1){1'b0}}, 1'b1};
      grant_idx_d = '0;
      grant_vld_d = 1'b1;
    end else begin
      grant_d     = rr_grant;
      grant_idx_d = rr_idx;
      grant_vld_d = rr_valid;
    end
  end

  // Priority grants leave the rotation pointer where it was.
  assign last_grant_d = (rr_valid && !eligible[0]) ? rr_idx : last_grant_q;
`else
  assign rr_elig      = eligible;
  assign grant_d      = rr_grant;
  assign grant_idx_d  = rr_idx;
  assign grant_vld_d  = rr_valid;
  assign last_grant_d = rr_valid ? rr_idx : last_grant_q;
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .eligible_i (rr_elig),
    .last_i     (last_grant_q),
    .grant_o    (rr_grant),
    .idx_o      (rr_idx),
    .valid_o    (rr_valid)
  );

  assign data_d = slice[grant_idx_d];

  // Occupancy: +1 per write, -1 per effective read, saturating at both ends.
  assign cred_inc = wr_active;
  assign cred_dec = fifo_rd && !fifo_empty;

  always_comb begin
    credits_d = credits_q;
    if (cred_inc && !cred_dec && (credits_q != CRED_MAX)) begin
      credits_d = credits_q + CW'(1);
    end else if (cred_dec && !cred_inc && (credits_q != '0)) begin
      credits_d = credits_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      fifo_data_q  <= '0;
      ack_q        <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      credits_q    <= '0;
    end else begin
      credits_q    <= credits_d;
      last_grant_q <= last_grant_d;
      ack_q        <= grant_d;
      case (state_q)
        IDLE:    if (grant_vld_d)  state_q <= ISSUE;
        ISSUE:   if (!grant_vld_d) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Data and id hold their last values when nothing is granted.
      if (grant_vld_d) begin
        fifo_data_q <= data_d;
        grant_id_q  <= grant_idx_d;
      end
    end
  end

  assign fifo_wd      = wr_active;
  assign fifo_data    = fifo_data_q;
  assign ack          = ack_q;
  assign grant_id     = grant_id_q;
  assign credits_used = credits_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (default build, plain round-robin).
// Expected writes are queued when producers are loaded and popped whenever the
// DUT drives fifo_wd; credit values and held outputs are checked directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic          fifo_full, fifo_rd, fifo_empty;
  logic          fifo_wd;
  logic [DW-1:0] fifo_data;
  logic [N-1:0]  ack;
  logic [1:0]    grant_id;
  logic [2:0]    credits_used;

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .DEPTH(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .fifo_rd      (fifo_rd),
    .fifo_empty   (fifo_empty),
    .fifo_wd      (fifo_wd),
    .fifo_data    (fifo_data),
    .ack          (ack),
    .grant_id     (grant_id),
    .credits_used (credits_used)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ackv;
    logic [1:0] id;
  } exp_t;

  exp_t  exp_q[$];
  int    wr_cyc[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    cyc        = 0;
  byte_t words [N][8];
  int    head [N];
  int    cnt  [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [3:0] a, input logic [1:0] id);
    exp_t e;
    e.data = d; e.ackv = a; e.id = id;
    exp_q.push_back(e);
  endtask

  // Present each producer's current word; a producer requests while it has words.
  task automatic drive_prod();
    for (int i = 0; i < N; i++) begin
      req[i] = (head[i] < cnt[i]);
      if (head[i] < cnt[i]) req_data[i*DW +: DW] = words[i][head[i]];
    end
  endtask

  task automatic load(input int p, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) words[p][j] = base + 8'(j);
    head[p] = 0;
    cnt[p]  = n;
    drive_prod();
  endtask

  task automatic clear_prod();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
    drive_prod();
  endtask

  // One clock: sample outputs just after the edge, score any write, then let
  // acked producers advance to their next word.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (fifo_wd === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(fifo_wd), 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("cycle %0d: write data=0x%02h ack=%b grant_id=%0d credits=%0d",
                 cyc, fifo_data, ack, grant_id, credits_used);
        check("wr_data", 32'(fifo_data), 32'(e.data));
        check("wr_ack", 32'(ack), 32'(e.ackv));
        check("wr_grant_id", 32'(grant_id), 32'(e.id));
      end
    end else begin
      check("ack_idle", 32'(ack), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1 && head[i] < cnt[i]) head[i]++;
    end
    drive_prod();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; req_data = '0;
    fifo_full = 1'b0; fifo_rd = 1'b0; fifo_empty = 1'b1;
    clear_prod();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wd", 32'(fifo_wd), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_credits", 32'(credits_used), 32'd0);
    rst = 1'b1;

    // All four producers at once: one write per cycle in order 0..3.
    for (int i = 0; i < N; i++) load(i, 8'h10 + 8'(i), 1);
    push_exp(8'h10, 4'b0001, 2'd0);
    push_exp(8'h11, 4'b0010, 2'd1);
    push_exp(8'h12, 4'b0100, 2'd2);
    push_exp(8'h13, 4'b1000, 2'd3);
    wr_cyc.delete();
    repeat (6) step();
    check("t1_nwr", 32'(wr_cyc.size()), 32'd4);
    if (wr_cyc.size() == 4) check("t1_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    check("t1_idle_wd", 32'(fifo_wd), 32'd0);
    check("t1_hold_data", 32'(fifo_data), 32'h13);
    check("t1_hold_id", 32'(grant_id), 32'd3);
    check("t1_credits", 32'(credits_used), 32'd4);
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    repeat (4) step();
    fifo_rd = 1'b0;
    check("t1_drained", 32'(credits_used), 32'd0);

    // Single producer streaming three words: ack every other cycle.
    wr_cyc.delete();
    load(2, 8'hA0, 3);
    push_exp(8'hA0, 4'b0100, 2'd2);
    push_exp(8'hA1, 4'b0100, 2'd2);
    push_exp(8'hA2, 4'b0100, 2'd2);
    repeat (8) step();
    check("t2_nwr", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) begin
      check("t2_gap1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
      check("t2_gap2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
    end
    check("t2_credits", 32'(credits_used), 32'd3);
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    repeat (3) step();
    fifo_rd = 1'b0;
    check("t2_drained", 32'(credits_used), 32'd0);

    // Credit ceiling: everyone requesting, no reads -> exactly 7 writes.
    wr_cyc.delete();
    for (int i = 0; i < N; i++) load(i, 8'h40 + 8'(16 * i), 3);
    push_exp(8'h70, 4'b1000, 2'd3);
    push_exp(8'h40, 4'b0001, 2'd0);
    push_exp(8'h50, 4'b0010, 2'd1);
    push_exp(8'h60, 4'b0100, 2'd2);
    push_exp(8'h71, 4'b1000, 2'd3);
    push_exp(8'h41, 4'b0001, 2'd0);
    push_exp(8'h51, 4'b0010, 2'd1);
    repeat (10) step();
    check("t3_nwr", 32'(wr_cyc.size()), 32'd7);
    check("t3_full_credits", 32'(credits_used), 32'd7);
    check("t3_blocked_wd", 32'(fifo_wd), 32'd0);
    push_exp(8'h61, 4'b0100, 2'd2);
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    step();
    fifo_rd = 1'b0;
    check("t3_after_read", 32'(credits_used), 32'd6);
    repeat (5) step();
    check("t3_one_more", 32'(wr_cyc.size()), 32'd8);
    check("t3_refull", 32'(credits_used), 32'd7);

    // Clean restart, then reset in the middle of a burst at credits_used=5.
    rst = 1'b0;
    #1;
    check("t5_async_credits", 32'(credits_used), 32'd0);
    clear_prod();
    step();
    rst = 1'b1;
    wr_cyc.delete();
    for (int i = 0; i < N; i++) load(i, 8'h80 + 8'(16 * i), 4);
    push_exp(8'h80, 4'b0001, 2'd0);
    push_exp(8'h90, 4'b0010, 2'd1);
    push_exp(8'hA0, 4'b0100, 2'd2);
    push_exp(8'hB0, 4'b1000, 2'd3);
    push_exp(8'h81, 4'b0001, 2'd0);
    push_exp(8'h91, 4'b0010, 2'd1);
    repeat (6) step();
    check("t5_burst_credits", 32'(credits_used), 32'd5);
    check("t5_burst_wd", 32'(fifo_wd), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_wd", 32'(fifo_wd), 32'd0);
    check("t5_rst_ack", 32'(ack), 32'd0);
    check("t5_rst_data", 32'(fifo_data), 32'd0);
    check("t5_rst_id", 32'(grant_id), 32'd0);
    check("t5_rst_credits", 32'(credits_used), 32'd0);
    clear_prod();
    step();
    rst = 1'b1;
    load(3, 8'hF3, 1);
    load(0, 8'hC0, 1);
    push_exp(8'hC0, 4'b0001, 2'd0);
    push_exp(8'hF3, 4'b1000, 2'd3);
    repeat (3) step();
    check("t5_credits2", 32'(credits_used), 32'd2);

    // Write and valid read together at credits_used=3: count unchanged.
    load(1, 8'hD1, 1);
    load(2, 8'hD2, 1);
    push_exp(8'hD1, 4'b0010, 2'd1);
    push_exp(8'hD2, 4'b0100, 2'd2);
    step();
    check("t4_credits_a", 32'(credits_used), 32'd2);
    step();
    check("t4_credits_b", 32'(credits_used), 32'd3);
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    step();
    fifo_rd = 1'b0;
    check("t4_simul", 32'(credits_used), 32'd3);
    fifo_rd = 1'b1;
    repeat (3) step();
    check("t4_drained", 32'(credits_used), 32'd0);
    fifo_empty = 1'b1;
    repeat (2) step();
    fifo_rd = 1'b0;
    check("t4_floor", 32'(credits_used), 32'd0);

    // fifo_full blocks grants even with credits available.
    wr_cyc.delete();
    fifo_full = 1'b1;
    load(0, 8'hE0, 1);
    repeat (3) step();
    check("t6_full_blocks", 32'(wr_cyc.size()), 32'd0);
    fifo_full = 1'b0;
    push_exp(8'hE0, 4'b0001, 2'd0);
    repeat (2) step();
    check("t6_released", 32'(wr_cyc.size()), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
